// File: rtl/lke_tcam_pipe.sv
// Ternary match-action lookup: DEPTH-entry TCAM with lowest-index priority,
// action RAM read at stage-2 load, two-stage valid/ready pipeline, hit/miss counters.
module lke_tcam_pipe #(
  parameter int PHV_LEN = 1024,
  parameter int KEY_LEN = 197,
  parameter int ACT_LEN = 625,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_LEN-1:0] key_in,
  input  logic [PHV_LEN-1:0] phv_in,
  input  logic               phv_valid,
  output logic               ready_out,
  output logic [ACT_LEN-1:0] action,
  output logic               action_valid,
  output logic [PHV_LEN-1:0] phv_out,
  output logic               hit,
  output logic [ADDR_W-1:0]  hit_addr,
  input  logic               ready_in,
  input  logic               cfg_wr,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [KEY_LEN-1:0] cfg_key,
  input  logic [KEY_LEN-1:0] cfg_mask,
  input  logic [ACT_LEN-1:0] cfg_act,
  input  logic               cfg_en,
  input  logic               cfg_clear,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt
);

  logic [KEY_LEN-1:0] key_mem  [DEPTH];
  logic [KEY_LEN-1:0] mask_mem [DEPTH];
  logic [ACT_LEN-1:0] act_mem  [DEPTH];
  logic [DEPTH-1:0]   vld;

  logic [DEPTH-1:0]   match;
  logic               match_any;
  logic [ADDR_W-1:0]  match_idx;
  logic               cfg_addr_ok;

  logic               s1_valid;
  logic [PHV_LEN-1:0] s1_phv;
  logic               s1_hit;
  logic [ADDR_W-1:0]  s1_idx;
  logic               s2_ready;
  logic               accept;
  logic               s2_load;

  if ((1 << ADDR_W) == DEPTH) begin : g_addr_full
    assign cfg_addr_ok = 1'b1;
  end else begin : g_addr_part
    assign cfg_addr_ok = ({{(32-ADDR_W){1'b0}}, cfg_addr} < 32'(DEPTH));
  end

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++)
      match[i] = vld[i] & ~|((key_in ^ key_mem[i]) & mask_mem[i]);
  end

  // Scan downwards so the lowest matching index is the last one assigned.
  always_comb begin
    match_any = |match;
    match_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (match[i]) match_idx = ADDR_W'(i);
  end

  always_ff @(posedge clk) begin
    if (cfg_wr && !cfg_clear && cfg_addr_ok) begin
      key_mem[cfg_addr]  <= cfg_key;
      mask_mem[cfg_addr] <= cfg_mask;
      act_mem[cfg_addr]  <= cfg_act;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      vld <= '0;
    else if (cfg_clear)
      vld <= '0;
    else if (cfg_wr && cfg_addr_ok)
      vld[cfg_addr] <= cfg_en;
  end

  // ready_out depends only on registered state and ready_in, never on phv_valid.
  assign s2_ready  = ~action_valid | ready_in;
  assign ready_out = ~s1_valid | s2_ready;
  assign accept    = phv_valid & ready_out;
  assign s2_load   = s1_valid & s2_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_phv   <= '0;
      s1_hit   <= 1'b0;
      s1_idx   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_phv   <= phv_in;
      s1_hit   <= match_any;
      s1_idx   <= match_idx;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      action_valid <= 1'b0;
      action       <= '0;
      phv_out      <= '0;
      hit          <= 1'b0;
      hit_addr     <= '0;
    end else if (s2_load) begin
      action_valid <= 1'b1;
      phv_out      <= s1_phv;
      hit          <= s1_hit;
      hit_addr     <= s1_hit ? s1_idx : '0;
      action       <= s1_hit ? act_mem[s1_idx] : '0;
    end else if (ready_in) begin
      action_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (s2_load) begin
      if (s1_hit) begin
        if (~&hit_cnt) hit_cnt <= hit_cnt + CNT_W'(1);
      end else begin
        if (~&miss_cnt) miss_cnt <= miss_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lke_tcam_pipe.sv
// Bench for lke_tcam_pipe: transaction-level reference model plus directed
// scenarios with hand-computed expectations, followed by randomized traffic.
module tb_lke_tcam_pipe;
  localparam int PHV_LEN = 32;
  localparam int KEY_LEN = 12;
  localparam int ACT_LEN = 24;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [KEY_LEN-1:0] key_in;
  logic [PHV_LEN-1:0] phv_in;
  logic               phv_valid;
  logic               ready_out;
  logic [ACT_LEN-1:0] action;
  logic               action_valid;
  logic [PHV_LEN-1:0] phv_out;
  logic               hit;
  logic [ADDR_W-1:0]  hit_addr;
  logic               ready_in;
  logic               cfg_wr;
  logic [ADDR_W-1:0]  cfg_addr;
  logic [KEY_LEN-1:0] cfg_key;
  logic [KEY_LEN-1:0] cfg_mask;
  logic [ACT_LEN-1:0] cfg_act;
  logic               cfg_en;
  logic               cfg_clear;
  logic               cnt_clr;
  logic [CNT_W-1:0]   hit_cnt;
  logic [CNT_W-1:0]   miss_cnt;

  lke_tcam_pipe #(
    .PHV_LEN(PHV_LEN), .KEY_LEN(KEY_LEN), .ACT_LEN(ACT_LEN),
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .phv_in(phv_in),
    .phv_valid(phv_valid), .ready_out(ready_out), .action(action),
    .action_valid(action_valid), .phv_out(phv_out), .hit(hit),
    .hit_addr(hit_addr), .ready_in(ready_in), .cfg_wr(cfg_wr),
    .cfg_addr(cfg_addr), .cfg_key(cfg_key), .cfg_mask(cfg_mask),
    .cfg_act(cfg_act), .cfg_en(cfg_en), .cfg_clear(cfg_clear),
    .cnt_clr(cnt_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [63:0] got,
                              input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  // Reference model: table contents plus an in-order queue of lookups in flight.
  typedef struct {
    logic [PHV_LEN-1:0] phv;
    logic               hit;
    logic [ADDR_W-1:0]  idx;
    logic [ACT_LEN-1:0] act;
    bit                 loaded;
  } item_t;

  item_t              q[$];
  logic [KEY_LEN-1:0] m_key  [DEPTH];
  logic [KEY_LEN-1:0] m_mask [DEPTH];
  logic [ACT_LEN-1:0] m_act  [DEPTH];
  bit                 m_vld  [DEPTH];
  int                 m_hit_cnt = 0;
  int                 m_miss_cnt = 0;
  bit                 m_live = 1'b0;
  bit                 m_rdy;
  bit                 m_load;
  logic               m_h;
  logic [ADDR_W-1:0]  m_ix;
  item_t              m_it;
  int                 dut_xfers = 0;

  function automatic void model_match(input logic [KEY_LEN-1:0] k,
                                      output logic h, output logic [ADDR_W-1:0] ix);
    h  = 1'b0;
    ix = '0;
    for (int i = 0; i < DEPTH; i++)
      if (!h && m_vld[i] && ((k ^ m_key[i]) & m_mask[i]) == '0) begin
        h  = 1'b1;
        ix = ADDR_W'(i);
      end
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
      m_hit_cnt  = 0;
      m_miss_cnt = 0;
      m_live     = 1'b1;
    end else if (m_live) begin
      // Two lookups in flight and the output not taken means the engine is full.
      m_rdy = (q.size() < 2) || ready_in;
      if (q.size() > 0 && q[0].loaded && ready_in) void'(q.pop_front());
      m_load = 1'b0;
      if (q.size() > 0 && !q[0].loaded) begin
        m_it        = q[0];
        m_it.loaded = 1'b1;
        m_it.act    = m_it.hit ? m_act[m_it.idx] : '0;
        q[0]        = m_it;
        m_load      = 1'b1;
      end
      if (cnt_clr) begin
        m_hit_cnt  = 0;
        m_miss_cnt = 0;
      end else if (m_load) begin
        if (q[0].hit) begin
          if (m_hit_cnt < CNT_MAX) m_hit_cnt++;
        end else if (m_miss_cnt < CNT_MAX) begin
          m_miss_cnt++;
        end
      end
      if (phv_valid && m_rdy) begin
        model_match(key_in, m_h, m_ix);
        m_it.phv    = phv_in;
        m_it.hit    = m_h;
        m_it.idx    = m_ix;
        m_it.act    = '0;
        m_it.loaded = 1'b0;
        q.push_back(m_it);
      end
      if (cfg_clear) begin
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
      end else if (cfg_wr) begin
        m_key[cfg_addr]  = cfg_key;
        m_mask[cfg_addr] = cfg_mask;
        m_act[cfg_addr]  = cfg_act;
        m_vld[cfg_addr]  = cfg_en;
      end
    end
  end

  always @(posedge clk)
    if (rst_n && action_valid && ready_in) dut_xfers++;

  always @(negedge clk) begin
    if (m_live && rst_n) begin
      chk("action_valid", 64'(action_valid), 64'(q.size() > 0 && q[0].loaded));
      chk("ready_out", 64'(ready_out), 64'((q.size() < 2) || ready_in));
      chk("hit_cnt", 64'(hit_cnt), 64'(m_hit_cnt));
      chk("miss_cnt", 64'(miss_cnt), 64'(m_miss_cnt));
      if (q.size() > 0 && q[0].loaded) begin
        chk("action", 64'(action), 64'(q[0].act));
        chk("hit", 64'(hit), 64'(q[0].hit));
        chk("hit_addr", 64'(hit_addr), 64'(q[0].hit ? q[0].idx : '0));
        chk("phv_out", 64'(phv_out), 64'(q[0].phv));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [ADDR_W-1:0] a, input logic [KEY_LEN-1:0] k,
                           input logic [KEY_LEN-1:0] m, input logic [ACT_LEN-1:0] act,
                           input logic en);
    cfg_addr = a; cfg_key = k; cfg_mask = m; cfg_act = act; cfg_en = en;
    cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
  endtask

  // One lookup into an idle engine; the result is examined two cycles after accept.
  task automatic lookup_check(input string nm, input logic [KEY_LEN-1:0] k,
                              input logic [PHV_LEN-1:0] p, input logic eh,
                              input logic [ADDR_W-1:0] ea, input logic [ACT_LEN-1:0] eact);
    key_in = k; phv_in = p; phv_valid = 1'b1;
    tick();
    phv_valid = 1'b0;
    tick();
    @(negedge clk);
    chk({nm, "_valid"}, 64'(action_valid), 64'(1));
    chk({nm, "_hit"}, 64'(hit), 64'(eh));
    chk({nm, "_addr"}, 64'(hit_addr), 64'(ea));
    chk({nm, "_action"}, 64'(action), 64'(eact));
    chk({nm, "_phv"}, 64'(phv_out), 64'(p));
  endtask

  int  sent;
  int  x0;
  bit  saw_low;

  initial begin
    rst_n = 1'b0; key_in = '0; phv_in = '0; phv_valid = 1'b0; ready_in = 1'b1;
    cfg_wr = 1'b0; cfg_addr = '0; cfg_key = '0; cfg_mask = '0; cfg_act = '0;
    cfg_en = 1'b0; cfg_clear = 1'b0; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_action_valid", 64'(action_valid), 64'(0));
    chk("rst_ready_out", 64'(ready_out), 64'(1));
    chk("rst_hit", 64'(hit), 64'(0));
    chk("rst_hit_addr", 64'(hit_addr), 64'(0));
    chk("rst_action", 64'(action), 64'(0));
    chk("rst_phv_out", 64'(phv_out), 64'(0));
    chk("rst_hit_cnt", 64'(hit_cnt), 64'(0));
    tick();

    // Exact-match entry
    cfg_write(4'd3, 12'hA5C, 12'hFFF, 24'hABCDEF, 1'b1);
    lookup_check("t1", 12'hA5C, 32'hDEAD0001, 1'b1, 4'd3, 24'hABCDEF);
    tick();

    // Priority between overlapping entries, invalidation, and a plain miss
    cfg_write(4'd1, 12'h123, 12'hFFF, 24'h111111, 1'b1);
    cfg_write(4'd5, 12'h000, 12'h000, 24'h555555, 1'b1);
    lookup_check("t2_prio", 12'h123, 32'h00000002, 1'b1, 4'd1, 24'h111111);
    tick();
    cfg_write(4'd1, 12'h123, 12'hFFF, 24'h111111, 1'b0);
    lookup_check("t2_fall", 12'h123, 32'h00000003, 1'b1, 4'd5, 24'h555555);
    tick();
    cfg_write(4'd5, 12'h000, 12'h000, 24'h555555, 1'b0);
    cfg_write(4'd1, 12'h123, 12'hFFF, 24'h111111, 1'b1);
    lookup_check("t2_miss", 12'h456, 32'h00000004, 1'b0, 4'd0, 24'h000000);
    tick();

    // Back-to-back stream with the output stalled for cycles 3-6
    x0 = dut_xfers; sent = 0; saw_low = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      ready_in  = !(c >= 3 && c <= 6);
      phv_valid = (sent < 8);
      phv_in    = 32'(100 + sent);
      key_in    = (sent % 2 == 0) ? 12'h123 : KEY_LEN'($urandom);
      @(negedge clk);
      if (!ready_out) saw_low = 1'b1;
      if (phv_valid && ready_out) sent++;
      tick();
    end
    phv_valid = 1'b0; ready_in = 1'b1;
    repeat (3) tick();
    chk("t3_sent", 64'(sent), 64'(8));
    chk("t3_delivered", 64'(dut_xfers - x0), 64'(8));
    chk("t3_ready_low_seen", 64'(saw_low), 64'(1));

    // Write racing a lookup, then clear beating write
    cfg_clear = 1'b1; tick(); cfg_clear = 1'b0;
    cfg_addr = 4'd2; cfg_key = 12'h2B2; cfg_mask = 12'hFFF; cfg_act = 24'h222222; cfg_en = 1'b1;
    cfg_wr = 1'b1; key_in = 12'h2B2; phv_in = 32'h44440001; phv_valid = 1'b1;
    tick();
    cfg_wr = 1'b0; phv_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("t4_race_valid", 64'(action_valid), 64'(1));
    chk("t4_race_hit", 64'(hit), 64'(0));
    chk("t4_race_action", 64'(action), 64'(0));
    lookup_check("t4_after", 12'h2B2, 32'h44440002, 1'b1, 4'd2, 24'h222222);
    tick();
    cfg_clear = 1'b1; cfg_wr = 1'b1; cfg_addr = 4'd2; cfg_en = 1'b1;
    tick();
    cfg_clear = 1'b0; cfg_wr = 1'b0;
    lookup_check("t4_clr", 12'h2B2, 32'h44440003, 1'b0, 4'd0, 24'h000000);
    tick();

    // Counter saturation and clear-beats-increment
    cfg_write(4'd0, 12'h000, 12'h000, 24'h0F0F0F, 1'b1);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    phv_valid = 1'b1;
    for (int i = 0; i < CNT_MAX - 1; i++) begin
      key_in = KEY_LEN'($urandom); phv_in = 32'($urandom);
      tick();
    end
    phv_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("t5_hit_cnt_254", 64'(hit_cnt), 64'(254));
    chk("t5_miss_cnt_0", 64'(miss_cnt), 64'(0));
    phv_valid = 1'b1;
    repeat (3) tick();
    phv_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("t5_hit_cnt_sat", 64'(hit_cnt), 64'(255));
    tick();
    key_in = 12'h777; phv_valid = 1'b1;
    tick();
    phv_valid = 1'b0; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("t5_clr_vs_hit", 64'(hit_cnt), 64'(0));
    tick();

    // Reset with both stages occupied
    ready_in = 1'b0; phv_valid = 1'b1; key_in = 12'h321;
    tick();
    tick();
    phv_valid = 1'b0;
    @(negedge clk);
    chk("t6_full_ready", 64'(ready_out), 64'(0));
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_rst_valid", 64'(action_valid), 64'(0));
    chk("t6_rst_ready", 64'(ready_out), 64'(1));
    ready_in = 1'b1;
    tick();
    lookup_check("t6_miss", 12'h321, 32'h66660001, 1'b0, 4'd0, 24'h000000);
    tick();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      phv_valid = ($urandom_range(0, 3) != 0);
      key_in    = KEY_LEN'($urandom);
      phv_in    = 32'($urandom);
      ready_in  = ($urandom_range(0, 3) != 0);
      cfg_wr    = ($urandom_range(0, 7) == 0);
      cfg_addr  = ADDR_W'($urandom);
      cfg_key   = KEY_LEN'($urandom);
      cfg_mask  = KEY_LEN'($urandom & $urandom & $urandom);
      cfg_act   = ACT_LEN'($urandom);
      cfg_en    = ($urandom_range(0, 3) != 0);
      cfg_clear = ($urandom_range(0, 299) == 0);
      cnt_clr   = ($urandom_range(0, 149) == 0);
      rst_n     = ($urandom_range(0, 799) != 0);
      tick();
    end
    phv_valid = 1'b0; cfg_wr = 1'b0; cfg_clear = 1'b0; cnt_clr = 1'b0;
    rst_n = 1'b1; ready_in = 1'b1;
    repeat (5) tick();
    chk("drain_empty", 64'(action_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
